// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch stage (master)
// and instruction memory (slave).
`ifndef SYS_ADDR_SPACE
`define SYS_ADDR_SPACE 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

interface if_fetch_unit_if #(
  parameter int AW = `SYS_ADDR_SPACE,
  parameter int IW = `INST_WIDTH
);
  logic          req;
  logic [AW-1:0] addr;
  logic          gnt;
  logic          rvalid;
  logic [IW-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: credit-based word fetch, in-order response FIFO and
// redirect flush with stale-response dropping. Optional: IF_MISALIGN_CHECK_EN.
`ifndef SYS_ADDR_SPACE
`define SYS_ADDR_SPACE 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module if_fetch_unit #(
  parameter int            AW         = `SYS_ADDR_SPACE,
  parameter int            IW         = `INST_WIDTH,
  parameter logic [AW-1:0] RESET_PC   = '0,
  parameter int            FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [AW-1:0]         redirect_pc_i,
  if_fetch_unit_if.master       imem,
  output logic [IW-1:0]         instr_o,
  output logic [AW-1:0]         pc_o,
`ifdef IF_MISALIGN_CHECK_EN
  output logic                  misalign_o,
`endif
  output logic                  valid_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [AW-1:0] fpc_q, fpc_d;
  logic [AW-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic [IW-1:0] instr_mem_q [FIFO_DEPTH];
  logic [AW-1:0] pc_mem_q    [FIFO_DEPTH];

  logic [AW-1:0] redirect_tgt;
  logic          req_block;
  logic [CW:0]   credit_used;
  logic          req;
  logic          gnt_fire;
  logic          rsp_fire;
  logic          push;
  logic          pop;

`ifdef IF_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  // A misaligned target parks fetch at that address until the next aligned redirect.
  assign redirect_tgt = redirect_pc_i;
  assign misalign_d   = redirect_i ? (redirect_pc_i[1:0] != 2'b00) : misalign_q;
  assign req_block    = misalign_q;
  assign misalign_o   = misalign_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end
`else
  assign redirect_tgt = redirect_pc_i & ~AW'(3);
  assign req_block    = 1'b0;
`endif

  // Outstanding requests plus buffered words never exceed the FIFO size.
  assign credit_used = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};
  assign req         = !rst_i && !redirect_i && !req_block && (credit_used < DEPTH_C);
  assign gnt_fire    = req && imem.gnt;
  assign rsp_fire    = imem.rvalid && (out_cnt_q != '0);
  assign push        = rsp_fire && (drop_cnt_q == '0) && !redirect_i;
  assign pop         = valid_o && !stall_i && !redirect_i;

  assign imem.req  = req;
  assign imem.addr = fpc_q;

  assign valid_o = (fifo_cnt_q != '0);
  assign instr_o = valid_o ? instr_mem_q[rd_ptr_q] : '0;
  assign pc_o    = valid_o ? pc_mem_q[rd_ptr_q]    : '0;

  always_comb begin
    fpc_d      = fpc_q;
    rsp_pc_d   = rsp_pc_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    fifo_cnt_d = fifo_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (redirect_i) begin
      // Everything still in flight belongs to the old path and must be dropped.
      fpc_d      = redirect_tgt;
      rsp_pc_d   = redirect_tgt;
      out_cnt_d  = out_cnt_q - CW'(rsp_fire);
      drop_cnt_d = out_cnt_q - CW'(rsp_fire);
      fifo_cnt_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (gnt_fire) fpc_d = fpc_q + AW'(4);
      out_cnt_d = out_cnt_q + CW'(gnt_fire) - CW'(rsp_fire);
      if (rsp_fire && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
      if (push) begin
        rsp_pc_d = rsp_pc_q + AW'(4);
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fpc_q      <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fpc_q      <= fpc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem.rdata;
      pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: in-order memory model with random
// grant/response timing and a count-based reference of the fetch stream.
`timescale 1ns/1ps
module tb_if_fetch_unit;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_i, stall_i, redirect_i;
  logic [AW-1:0] redirect_pc_i;
  logic [IW-1:0] instr_o;
  logic [AW-1:0] pc_o;
  logic valid_o;
`ifdef IF_MISALIGN_CHECK_EN
  logic misalign_o;
`endif

  if_fetch_unit_if #(.AW(AW), .IW(IW)) imem ();

  if_fetch_unit #(.AW(AW), .IW(IW), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem(imem), .instr_o(instr_o), .pc_o(pc_o),
`ifdef IF_MISALIGN_CHECK_EN
    .misalign_o(misalign_o),
`endif
    .valid_o(valid_o));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int unsigned cyc; } pend_t;

  int errors = 0, checks = 0;
  pend_t mq[$];
  int unsigned cyc_n = 0;
  int unsigned gnt_pct = 100, rsp_pct = 100;
  bit inject_stale = 0;

  int m_fifo = 0, m_drop = 0;
  logic [31:0] m_head = RST_PC, m_fetch = RST_PC;
  bit m_mis = 0;

  logic o_req, o_valid, o_mis;
  logic [31:0] o_addr, o_pc, o_instr;
  logic e_req, e_valid, e_mis;
  logic [31:0] e_addr, e_pc, e_instr;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef IF_MISALIGN_CHECK_EN
    return t;
`else
    return t & 32'hFFFF_FFFC;
`endif
  endfunction

  task automatic sample_outputs();
    o_req = imem.req; o_addr = imem.addr; o_valid = valid_o; o_pc = pc_o; o_instr = instr_o;
`ifdef IF_MISALIGN_CHECK_EN
    o_mis = misalign_o;
`else
    o_mis = 1'b0;
`endif
  endtask

  // One clock: drive inputs, sample at negedge, advance memory and reference.
  task automatic tick(input bit st, input bit rd, input logic [31:0] tg);
    bit rv, real_rsp, push, pop;
    stall_i = st; redirect_i = rd; redirect_pc_i = tg;
    imem.gnt = ($urandom_range(99) < gnt_pct);
    rv = 0; imem.rdata = '0;
    if (mq.size() > 0) begin
      if (mq[0].cyc < cyc_n && $urandom_range(99) < rsp_pct) begin
        rv = 1; imem.rdata = mem_data(mq[0].addr);
      end
    end else if (inject_stale) begin
      rv = 1; imem.rdata = $urandom; inject_stale = 0;
    end
    imem.rvalid = rv;
    @(negedge clk);
    sample_outputs();
    e_req = !rd && !m_mis && (mq.size() + m_fifo < DEPTH);
    e_addr = m_fetch;
    e_valid = (m_fifo > 0);
    e_pc = e_valid ? m_head : 32'h0;
    e_instr = e_valid ? mem_data(m_head) : 32'h0;
    e_mis = m_mis;
    real_rsp = rv && (mq.size() > 0);
    if (real_rsp) void'(mq.pop_front());
    if (rd) begin
      m_fifo = 0; m_drop = mq.size();
      m_head = eff_target(tg); m_fetch = eff_target(tg);
`ifdef IF_MISALIGN_CHECK_EN
      m_mis = (tg[1:0] != 2'b00);
`endif
    end else begin
      push = 0;
      if (real_rsp) begin
        if (m_drop > 0) m_drop--;
        else push = 1;
      end
      pop = e_valid && !st;
      if (e_req && imem.gnt) m_fetch += 4;
      if (pop) begin m_head += 4; m_fifo--; end
      if (push) m_fifo++;
    end
    if (o_req && imem.gnt) mq.push_back('{addr: o_addr, cyc: cyc_n});
    @(posedge clk); #1;
    cyc_n++;
  endtask

  task automatic do_reset(input bit stale);
    rst_i = 1; stall_i = 0; redirect_i = 0; redirect_pc_i = '0;
    imem.gnt = 0; imem.rvalid = 0; imem.rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sample_outputs();
    @(posedge clk); #1;
    rst_i = 0;
    mq.delete(); inject_stale = stale;
    m_fifo = 0; m_drop = 0; m_head = RST_PC; m_fetch = RST_PC; m_mis = 0; cyc_n = 0;
  endtask

  task automatic test_reset();
    do_reset(0);
    checks += 5;
    if (o_req !== 1'b0)   begin errors++; $display("FAIL reset_req got=%b exp=0", o_req); end
    if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    if (o_pc !== 32'h0)   begin errors++; $display("FAIL reset_pc got=%h exp=0", o_pc); end
    if (o_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", o_instr); end
    if (o_mis !== 1'b0)   begin errors++; $display("FAIL reset_misalign got=%b exp=0", o_mis); end
  endtask

  task automatic test_stream();
    gnt_pct = 100; rsp_pct = 100;
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 0);
      checks += 2;
      if (o_valid !== (i >= 2)) begin errors++; $display("FAIL stream_valid i=%0d got=%b exp=%b", i, o_valid, i >= 2); end
      if (i >= 2 && o_pc !== 32'(4 * (i - 2))) begin errors++; $display("FAIL stream_pc i=%0d got=%h exp=%h", i, o_pc, 4 * (i - 2)); end
      if (i == 0) begin
        checks++;
        if (o_req !== 1'b1 || o_addr !== RST_PC) begin errors++; $display("FAIL first_req got=%b/%h exp=1/%h", o_req, o_addr, RST_PC); end
      end
      checks++;
      if (o_instr !== e_instr) begin errors++; $display("FAIL stream_instr i=%0d got=%h exp=%h", i, o_instr, e_instr); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] p0;
    p0 = 32'h0;
    for (int i = 0; i < 6; i++) begin
      tick(1, 0, 0);
      if (i == 0) p0 = o_pc;
      checks += 3;
      if (o_valid !== 1'b1 || o_pc !== e_pc) begin errors++; $display("FAIL stall_head i=%0d got=%b/%h exp=1/%h", i, o_valid, o_pc, e_pc); end
      if (o_pc !== p0 || o_instr !== mem_data(p0)) begin errors++; $display("FAIL stall_hold i=%0d got=%h/%h exp=%h/%h", i, o_pc, o_instr, p0, mem_data(p0)); end
      if (o_req !== e_req || (i >= 4 && o_req !== 1'b0)) begin errors++; $display("FAIL stall_req i=%0d got=%b exp=%b", i, o_req, e_req); end
    end
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0);
      checks += 2;
      if (o_valid !== 1'b1 || o_pc !== p0 + 32'(4 * i)) begin errors++; $display("FAIL stall_resume i=%0d got=%b/%h exp=1/%h", i, o_valid, o_pc, p0 + 32'(4 * i)); end
      if (o_instr !== e_instr) begin errors++; $display("FAIL stall_resume_instr i=%0d got=%h exp=%h", i, o_instr, e_instr); end
    end
  endtask

  task automatic test_redirect();
    bit seen;
    gnt_pct = 100; rsp_pct = 0;
    tick(0, 1, 32'h40);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 1, 32'h100);
    rsp_pct = 100;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(0, 0, 0);
      checks++;
      if (o_valid !== e_valid || o_pc !== e_pc) begin errors++; $display("FAIL redir_model i=%0d got=%b/%h exp=%b/%h", i, o_valid, o_pc, e_valid, e_pc); end
      if (o_valid === 1'b1) begin
        seen = 1;
        checks += 2;
        if (o_pc !== 32'h100) begin errors++; $display("FAIL redir_first_pc got=%h exp=100", o_pc); end
        if (o_instr !== mem_data(32'h100)) begin errors++; $display("FAIL redir_first_instr got=%h exp=%h", o_instr, mem_data(32'h100)); end
      end
    end
    if (!seen) begin checks++; errors++; $display("FAIL redir_timeout got=no_valid exp=valid"); end
  endtask

  task automatic test_redir_rsp_stall();
    gnt_pct = 100; rsp_pct = 0;
    repeat (3) tick(0, 0, 0);
    rsp_pct = 100;
    tick(1, 1, 32'h100);
    rsp_pct = 0;
    tick(0, 0, 0);
    checks += 3;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL combo_valid got=%b exp=0", o_valid); end
    if (o_req !== 1'b1)   begin errors++; $display("FAIL combo_req got=%b exp=1", o_req); end
    if (o_addr !== 32'h100) begin errors++; $display("FAIL combo_addr got=%h exp=100", o_addr); end
    rsp_pct = 100;
    repeat (6) tick(0, 0, 0);
  endtask

  task automatic test_gnt_hold();
    logic [31:0] a0;
    a0 = 32'h0;
    gnt_pct = 0; rsp_pct = 100;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0);
      if (i == 0) a0 = o_addr;
      checks += 2;
      if (o_req !== 1'b1) begin errors++; $display("FAIL hold_req i=%0d got=%b exp=1", i, o_req); end
      if (o_addr !== e_addr || o_addr !== a0) begin errors++; $display("FAIL hold_addr i=%0d got=%h exp=%h", i, o_addr, e_addr); end
    end
    gnt_pct = 100;
    tick(0, 0, 0);
    tick(0, 0, 0);
    checks++;
    if (o_req !== 1'b1 || o_addr !== a0 + 32'h4) begin errors++; $display("FAIL hold_advance got=%b/%h exp=1/%h", o_req, o_addr, a0 + 32'h4); end
  endtask

  task automatic test_target_align();
    bit seen;
    gnt_pct = 100; rsp_pct = 100;
    tick(0, 1, 32'h102);
`ifdef IF_MISALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0);
      checks += 3;
      if (o_mis !== 1'b1)   begin errors++; $display("FAIL mis_flag i=%0d got=%b exp=1", i, o_mis); end
      if (o_req !== 1'b0)   begin errors++; $display("FAIL mis_req i=%0d got=%b exp=0", i, o_req); end
      if (o_valid !== 1'b0) begin errors++; $display("FAIL mis_valid i=%0d got=%b exp=0", i, o_valid); end
    end
    tick(0, 1, 32'h200);
    tick(0, 0, 0);
    checks += 2;
    if (o_mis !== 1'b0) begin errors++; $display("FAIL mis_clear got=%b exp=0", o_mis); end
    if (o_req !== 1'b1 || o_addr !== 32'h200) begin errors++; $display("FAIL mis_refetch got=%b/%h exp=1/200", o_req, o_addr); end
`else
    tick(0, 0, 0);
    checks++;
    if (o_req !== 1'b1 || o_addr !== 32'h100) begin errors++; $display("FAIL align_addr got=%b/%h exp=1/100", o_req, o_addr); end
`endif
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(0, 0, 0);
      if (o_valid === 1'b1) begin
        seen = 1;
        checks++;
        if (o_pc !== e_pc || o_instr !== e_instr) begin errors++; $display("FAIL align_head got=%h/%h exp=%h/%h", o_pc, o_instr, e_pc, e_instr); end
      end
    end
    if (!seen) begin checks++; errors++; $display("FAIL align_timeout got=no_valid exp=valid"); end
  endtask

  task automatic test_random();
    bit st, rd;
    logic [31:0] tg;
    gnt_pct = 70; rsp_pct = 70;
    for (int i = 0; i < 500; i++) begin
      st = ($urandom_range(99) < 30);
      rd = ($urandom_range(99) < 4);
      tg = $urandom & 32'h0000_FFFF;
`ifdef IF_MISALIGN_CHECK_EN
      if ($urandom_range(3) != 0) tg[1:0] = 2'b00;
`endif
      tick(st, rd, tg);
      checks += 3;
      if (o_req !== e_req) begin errors++; $display("FAIL rand_req i=%0d got=%b exp=%b", i, o_req, e_req); end
      if (o_valid !== e_valid || o_pc !== e_pc || o_instr !== e_instr) begin
        errors++; $display("FAIL rand_head i=%0d got=%b/%h/%h exp=%b/%h/%h", i, o_valid, o_pc, o_instr, e_valid, e_pc, e_instr);
      end
      if (o_mis !== e_mis) begin errors++; $display("FAIL rand_mis i=%0d got=%b exp=%b", i, o_mis, e_mis); end
      if (e_req) begin
        checks++;
        if (o_addr !== e_addr) begin errors++; $display("FAIL rand_addr i=%0d got=%h exp=%h", i, o_addr, e_addr); end
      end
    end
  endtask

  task automatic test_reset_mid();
    gnt_pct = 100; rsp_pct = 0;
    tick(0, 1, 32'h80);
    repeat (3) tick(0, 0, 0);
    do_reset(1);
    checks += 2;
    if (o_req !== 1'b0)   begin errors++; $display("FAIL midrst_req got=%b exp=0", o_req); end
    if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", o_valid); end
    rsp_pct = 100;
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0);
      checks += 2;
      if (o_valid !== (i >= 2)) begin errors++; $display("FAIL midrst_seq i=%0d got=%b exp=%b", i, o_valid, i >= 2); end
      if (o_pc !== e_pc || o_instr !== e_instr) begin errors++; $display("FAIL midrst_head i=%0d got=%h/%h exp=%h/%h", i, o_pc, o_instr, e_pc, e_instr); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redir_rsp_stall();
    test_gnt_hold();
    test_target_align();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
